fetch_unit: RTL and testbench

- Instruction fetch stage directly downstream of the program counter (PC).
- Takes the PC's 12-bit execadd and issues a single-word read to instruction memory with a req/ack handshake.
- Latches the returned 16-bit word into the instruction register (IR), splits it into opcode and operand, and hands it to the decoder with a valid/ready handshake.
- Generates the PC's incPC pulse; the operand field feeds the PC's address input for jumps.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_timeout_ctr.sv | 37 +++
 rtl/fetch_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: field widths, IR field
// positions and the fetch FSM state encoding.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 16;
  localparam int OPC_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 15;

  // IR layout: opcode in the top nibble, operand (jump target) below it
  localparam int OPC_MSB = DATA_W_DEF - 1;
  localparam int OPC_LSB = DATA_W_DEF - OPC_W_DEF;
  localparam int OPD_MSB = DATA_W_DEF - OPC_W_DEF - 1;
  localparam int OPD_LSB = 0;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE = 2'd0;
  localparam fetch_state_t ST_REQ  = 2'd1;
  localparam fetch_state_t ST_HOLD = 2'd2;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Memory-acknowledge watchdog: down-counter loaded on request start, with a
// terminal-count flag. Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Loading TIMEOUT-1 makes tc_o coincide with the TIMEOUT-th waiting cycle
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(TIMEOUT - 1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC address -> memory read -> IR -> decoder.
// Optional ack watchdog and sticky fetch_err enabled by FETCH_TIMEOUT_EN.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | no fetch in flight; starts one when run (and no error)
//   REQ     | mem_rd held with stable mem_addr until mem_ack
//   HOLD    | IR valid, waiting for the decoder to take it
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OPC_W  = OPC_W_DEF
`ifdef FETCH_TIMEOUT_EN
  , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              flush,
  input  logic [ADDR_W-1:0] execadd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] operand,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              incPC,
  output logic              fetch_err
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              incpc_q, incpc_d;
  logic              tmo_hit;
  logic              fetch_block;

`ifdef FETCH_TIMEOUT_EN
  logic fetch_err_q;
  logic tmo_load, tmo_dec, tmo_tc;

  assign tmo_load = (state_q == ST_IDLE) && run && !flush && !fetch_err_q;
  assign tmo_dec  = (state_q == ST_REQ) && !mem_ack && !flush;
  assign tmo_hit  = (state_q == ST_REQ) && !mem_ack && tmo_tc;
  assign fetch_block = fetch_err_q;

  fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(tmo_load),
    .dec_i (tmo_dec),
    .tc_o  (tmo_tc)
  );

  // Sticky until flush or reset; flush wins over a simultaneous timeout
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      fetch_err_q <= 1'b0;
    end else if (tmo_hit) begin
      fetch_err_q <= 1'b1;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign fetch_block = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    incpc_d    = 1'b0;
    if (flush) begin
      state_d    = ST_IDLE;
      mem_rd_d   = 1'b0;
      ir_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run && !fetch_block) begin
            state_d    = ST_REQ;
            mem_addr_d = execadd;
            mem_rd_d   = 1'b1;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state_d    = ST_HOLD;
            ir_d       = mem_rdata;
            ir_valid_d = 1'b1;
            incpc_d    = 1'b1;
            mem_rd_d   = 1'b0;
          end else if (tmo_hit) begin
            state_d  = ST_IDLE;
            mem_rd_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (ir_ready) begin
            state_d    = ST_IDLE;
            ir_valid_d = 1'b0;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          mem_rd_d   = 1'b0;
          ir_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      incpc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      incpc_q    <= incpc_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign incPC    = incpc_q;
  assign opcode   = ir_q[DATA_W-1 -: OPC_W];
  assign operand  = ir_q[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of fetch vectors plus hand-written
// flush, reset and (with FETCH_TIMEOUT_EN) timeout sequences.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        flush;
  logic [11:0] execadd;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ir;
  logic [3:0]  opcode;
  logic [11:0] operand;
  logic        ir_valid;
  logic        ir_ready;
  logic        incPC;
  logic        fetch_err;

  fetch_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .flush    (flush),
    .execadd  (execadd),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .ir       (ir),
    .opcode   (opcode),
    .operand  (operand),
    .ir_valid (ir_valid),
    .ir_ready (ir_ready),
    .incPC    (incPC),
    .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter model: loadable, increments on incPC
  logic        pc_load;
  logic [11:0] pc_load_val;
  always @(posedge clk) begin
    if (pc_load) execadd <= pc_load_val;
    else if (incPC) execadd <= execadd + 12'd1;
  end

  int inc_cnt = 0;
  int rd_cnt  = 0;
  always @(negedge clk) begin
    if (incPC) inc_cnt++;
    if (mem_rd) rd_cnt++;
  end

  int checks   = 0;
  int failures = 0;
  logic [15:0] sb[$];
  logic [15:0] last_ir;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic load_pc(input logic [11:0] v);
    pc_load = 1'b1;
    pc_load_val = v;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  task automatic do_fetch(input string nm, input logic [15:0] data, input int ack_dly,
                          input int rdy_dly, input logic [11:0] exp_addr,
                          input logic [3:0] exp_opc, input logic [11:0] exp_opd);
    int inc0, rd0;
    logic [15:0] got;
    @(negedge clk);
    #1;
    inc0 = inc_cnt;
    rd0  = rd_cnt;
    run  = 1'b1;
    @(negedge clk);
    check({nm, " req"}, 32'(mem_rd), 32'd1);
    check({nm, " addr"}, 32'(mem_addr), 32'(exp_addr));
    for (int k = 0; k < ack_dly; k++) begin
      @(negedge clk);
      check({nm, " rd_hold"}, 32'(mem_rd), 32'd1);
      check({nm, " addr_hold"}, 32'(mem_addr), 32'(exp_addr));
    end
    mem_ack   = 1'b1;
    mem_rdata = data;
    run       = 1'b0;
    sb.push_back(data);
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 16'($urandom);
    check({nm, " valid"}, 32'(ir_valid), 32'd1);
    check({nm, " incpc"}, 32'(incPC), 32'd1);
    check({nm, " rd_drop"}, 32'(mem_rd), 32'd0);
    for (int r = 0; r < rdy_dly; r++) begin
      check({nm, " valid_hold"}, 32'(ir_valid), 32'd1);
      check({nm, " ir_hold"}, 32'(ir), 32'(data));
      @(negedge clk);
    end
    ir_ready = 1'b1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty actual=none required=%0h", nm, data);
    end else begin
      got = sb.pop_front();
      check({nm, " ir"}, 32'(ir), 32'(got));
    end
    check({nm, " opcode"}, 32'(opcode), 32'(exp_opc));
    check({nm, " operand"}, 32'(operand), 32'(exp_opd));
    @(negedge clk);
    ir_ready = 1'b0;
    check({nm, " valid_clr"}, 32'(ir_valid), 32'd0);
    check({nm, " ir_keep"}, 32'(ir), 32'(data));
    check({nm, " incpc_once"}, 32'(incPC), 32'd0);
    check({nm, " idle_rd"}, 32'(mem_rd), 32'd0);
    check({nm, " err"}, 32'(fetch_err), 32'd0);
    #1;
    check({nm, " incpc_cnt"}, 32'(inc_cnt - inc0), 32'd1);
    check({nm, " rd_cycles"}, 32'(rd_cnt - rd0), 32'(ack_dly + 1));
    last_ir = data;
  endtask

  typedef struct {
    logic        ld;
    logic [11:0] addr;
    logic [15:0] rdata;
    int          ack_dly;
    int          rdy_dly;
    logic [11:0] exp_addr;
    logic [3:0]  exp_opc;
    logic [11:0] exp_opd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int inc0;
    int cnt;
    vecs[0] = '{1'b1, 12'h005, 16'hA123, 0, 0, 12'h005, 4'hA, 12'h123};
    vecs[1] = '{1'b0, 12'h000, 16'h5B7C, 0, 0, 12'h006, 4'h5, 12'hB7C};
    vecs[2] = '{1'b1, 12'h200, 16'h1FFE, 4, 3, 12'h200, 4'h1, 12'hFFE};
    vecs[3] = '{1'b1, 12'hFFF, 16'hF000, 1, 1, 12'hFFF, 4'hF, 12'h000};
    vecs[4] = '{1'b0, 12'h000, 16'h0C3D, 2, 0, 12'h000, 4'h0, 12'hC3D};
    vecs[5] = '{1'b1, 12'h0AA, 16'hFFFF, 0, 2, 12'h0AA, 4'hF, 12'hFFF};

    rst_n = 1'b0; run = 1'b1; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    ir_ready = 1'b0; pc_load = 1'b1; pc_load_val = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst mem_rd", 32'(mem_rd), 32'd0);
      check("rst mem_addr", 32'(mem_addr), 32'd0);
      check("rst ir", 32'(ir), 32'd0);
      check("rst ir_valid", 32'(ir_valid), 32'd0);
      check("rst incpc", 32'(incPC), 32'd0);
      check("rst err", 32'(fetch_err), 32'd0);
    end
    run = 1'b0; rst_n = 1'b1; pc_load = 1'b0;
    last_ir = '0;

    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].ld) load_pc(vecs[i].addr);
      do_fetch($sformatf("vec%0d", i), vecs[i].rdata, vecs[i].ack_dly, vecs[i].rdy_dly,
               vecs[i].exp_addr, vecs[i].exp_opc, vecs[i].exp_opd);
    end

    // Flush together with ack: data dropped, no pulse, next fetch uses new PC
    @(negedge clk);
    load_pc(12'h050);
    #1; inc0 = inc_cnt;
    run = 1'b1;
    @(negedge clk);
    check("flush_ack req", 32'(mem_rd), 32'd1);
    flush = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD; run = 1'b0;
    @(negedge clk);
    flush = 1'b0; mem_ack = 1'b0;
    check("flush_ack mem_rd", 32'(mem_rd), 32'd0);
    check("flush_ack ir_valid", 32'(ir_valid), 32'd0);
    check("flush_ack incpc", 32'(incPC), 32'd0);
    check("flush_ack ir", 32'(ir), 32'(last_ir));
    @(negedge clk);
    check("flush_ack idle", 32'(mem_rd), 32'd0);
    #1;
    check("flush_ack incpc_cnt", 32'(inc_cnt - inc0), 32'd0);
    load_pc(12'h100);
    do_fetch("flush_next", 16'h3ABC, 0, 0, 12'h100, 4'h3, 12'hABC);

    // Flush while IR is waiting for the decoder
    @(negedge clk);
    load_pc(12'h010);
    run = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 16'h9E01; run = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    check("flush_hold valid", 32'(ir_valid), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_hold valid_clr", 32'(ir_valid), 32'd0);
    check("flush_hold ir", 32'(ir), 32'h9E01);
    last_ir = 16'h9E01;

`ifdef FETCH_TIMEOUT_EN
    @(negedge clk);
    load_pc(12'h300);
    #1; inc0 = inc_cnt;
    run = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!mem_rd) break;
      cnt++;
    end
    check("tmo rd_cycles", 32'(cnt), 32'd15);
    check("tmo err", 32'(fetch_err), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("tmo no_refetch", 32'(mem_rd), 32'd0);
    end
    #1;
    check("tmo incpc_cnt", 32'(inc_cnt - inc0), 32'd0);
    check("tmo ir", 32'(ir), 32'(last_ir));
    flush = 1'b1; run = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    check("tmo err_clr", 32'(fetch_err), 32'd0);
    do_fetch("tmo_resume", 16'h4321, 0, 0, 12'h300, 4'h4, 12'h321);
`else
    @(negedge clk);
    load_pc(12'h300);
    do_fetch("slow_mem", 16'h4321, 20, 0, 12'h300, 4'h4, 12'h321);
`endif

    // Reset in REQ, then a stray ack: ignored
    @(negedge clk);
    load_pc(12'h123);
    run = 1'b1;
    @(negedge clk);
    check("rst_req req", 32'(mem_rd), 32'd1);
    rst_n = 1'b0; run = 1'b0;
    @(negedge clk);
    check("rst_req mem_rd", 32'(mem_rd), 32'd0);
    check("rst_req ir", 32'(ir), 32'd0);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h7777;
    #1; inc0 = inc_cnt;
    @(negedge clk);
    mem_ack = 1'b0;
    check("rst_req ack_ign valid", 32'(ir_valid), 32'd0);
    check("rst_req ack_ign ir", 32'(ir), 32'd0);
    check("rst_req ack_ign incpc", 32'(incPC), 32'd0);
    check("rst_req ack_ign rd", 32'(mem_rd), 32'd0);
    @(negedge clk);
    #1;
    check("rst_req incpc_cnt", 32'(inc_cnt - inc0), 32'd0);
    check("sb drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
